// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word reads over req/gnt/rvalid, buffers
// returned words with their PC in an in-order FIFO and squashes stale fetches on redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] outstanding_reg, outstanding_next;
    logic [CW-1:0] discard_reg, discard_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [CW:0] in_use;
    logic        fifo_empty;
    logic        issue;
    logic        rsp;
    logic        push;
    logic        pop;
    logic [31:0] target_pc;
    logic        redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];
    assign target_pc           = {redirect_pc[31:2], 2'b00};

    always_comb begin
        in_use     = {1'b0, outstanding_reg} + {1'b0, count_reg};
        fifo_empty = (count_reg == '0);

        imem_req  = !rst && !redirect_valid && (in_use < DEPTH_W);
        imem_addr = fetch_pc_reg;
        issue     = imem_req && imem_gnt;

        // A response with nothing outstanding is a protocol error and is ignored.
        rsp  = imem_rvalid && (outstanding_reg != '0);
        push = rsp && (discard_reg == '0) && !redirect_valid;

        instr_valid = !fifo_empty && !redirect_valid;
        instr       = fifo_empty ? 32'h0 : data_mem[rd_ptr_reg];
        instr_pc    = fifo_empty ? 32'h0 : pc_mem[rd_ptr_reg];
        pop         = instr_valid && instr_ready;

        outstanding_next = outstanding_reg;
        if (issue && !rsp) begin
            outstanding_next = outstanding_reg + CW'(1);
        end else if (!issue && rsp) begin
            outstanding_next = outstanding_reg - CW'(1);
        end

        // Every fetch still in flight after a redirect belongs to the old path.
        discard_next = discard_reg;
        if (redirect_valid) begin
            discard_next = outstanding_next;
        end else if (rsp && (discard_reg != '0)) begin
            discard_next = discard_reg - CW'(1);
        end

        fetch_pc_next = issue ? fetch_pc_reg + 32'd4 : fetch_pc_reg;
        resp_pc_next  = push ? resp_pc_reg + 32'd4 : resp_pc_reg;
        wr_ptr_next   = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next   = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_next = target_pc;
            resp_pc_next  = target_pc;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            count_reg       <= count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model checked every cycle,
// a one-cycle-latency memory responder, and directed scenarios with literal expectations.
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int grants = 0;
    bit hold   = 1'b0;
    bit stray  = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] delivered[$];

    // Reference model: pending fetches tagged stale/live, FIFO of PCs.
    logic [31:0] m_fetch_pc, m_resp_pc;
    logic [31:0] m_fifo[$];
    bit          m_stale[$];
    bit          st;
    logic        e_req, e_valid;
    logic [31:0] e_pc, e_instr;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a * 32'd3 + 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory responder: data one cycle after grant, unless held.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end else if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end else if (!hold && pend.size() != 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mw(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            #1;
            if (!rst && imem_req && imem_gnt) begin
                pend.push_back(imem_addr);
                grants++;
            end
        end
    end

    // Compare process: checks all outputs every cycle, then advances the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_fetch_pc = RESET_PC;
                m_resp_pc  = RESET_PC;
                m_fifo.delete();
                m_stale.delete();
            end
            e_req   = !rst && !redirect_valid && ((m_stale.size() + m_fifo.size()) < DEPTH);
            e_valid = (m_fifo.size() != 0) && !redirect_valid;
            e_pc    = (m_fifo.size() != 0) ? m_fifo[0] : 32'h0;
            e_instr = (m_fifo.size() != 0) ? mw(m_fifo[0]) : 32'h0;
            check_bit("model_req", imem_req, e_req);
            check("model_addr", imem_addr, m_fetch_pc);
            check_bit("model_valid", instr_valid, e_valid);
            check("model_pc", instr_pc, e_pc);
            check("model_instr", instr, e_instr);
            if (!rst) begin
                if (e_valid && instr_ready) begin
                    delivered.push_back(instr_pc);
                    $display("instr pc=%h data=%h", instr_pc, instr);
                    void'(m_fifo.pop_front());
                end
                if (imem_rvalid && m_stale.size() != 0) begin
                    st = m_stale.pop_front();
                    if (!st && !redirect_valid) begin
                        m_fifo.push_back(m_resp_pc);
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                end
                if (redirect_valid) begin
                    m_fifo.delete();
                    foreach (m_stale[i]) m_stale[i] = 1'b1;
                    m_fetch_pc = {redirect_pc[31:2], 2'b00};
                    m_resp_pc  = {redirect_pc[31:2], 2'b00};
                end
                if (e_req && imem_gnt) begin
                    m_stale.push_back(1'b0);
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; hold = 1'b0; stray = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        delivered.delete();
        grants = 0;
    endtask

    initial begin
        int n;
        logic [31:0] a0;

        #1 rst = 1'b1;
        #1;
        check_bit("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check_bit("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);

        // Startup stream
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1;
        #3;
        check_bit("start_req", imem_req, 1'b1);
        check("start_addr0", imem_addr, 32'h0);
        @(negedge clk); #3;
        check_bit("start_valid_n1", instr_valid, 1'b0);
        check("start_addr1", imem_addr, 32'h4);
        @(negedge clk); #3;
        check_bit("start_valid_n2", instr_valid, 1'b1);
        check("start_pc0", instr_pc, 32'h0);
        check("start_data0", instr, mw(32'h0));
        check("start_addr2", imem_addr, 32'h8);
        repeat (6) @(negedge clk);
        #3;
        check_bit("start_count", delivered.size() >= 3, 1'b1);
        if (delivered.size() >= 3) begin
            check("start_seq0", delivered[0], 32'h0);
            check("start_seq1", delivered[1], 32'h4);
            check("start_seq2", delivered[2], 32'h8);
        end

        // Backpressure
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("bp_grants", 32'(grants), 32'd2);
        check_bit("bp_req", imem_req, 1'b0);
        check_bit("bp_valid", instr_valid, 1'b1);
        check("bp_head", instr_pc, 32'h0);
        @(negedge clk);
        instr_ready = 1'b1;
        delivered.delete();
        repeat (8) @(negedge clk);
        #3;
        check_bit("bp_count", delivered.size() >= 3, 1'b1);
        if (delivered.size() >= 3) begin
            check("bp_seq0", delivered[0], 32'h0);
            check("bp_seq1", delivered[1], 32'h4);
            check("bp_seq2", delivered[2], 32'h8);
            for (int i = 0; i + 1 < delivered.size(); i++)
                check("bp_inorder", delivered[i + 1], delivered[i] + 32'd4);
        end

        // Redirect with two fetches in flight
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1;
        for (n = 0; n < 30; n++) begin
            @(negedge clk); #3;
            if (imem_req && imem_gnt && imem_addr == 32'h8) break;
        end
        check_bit("rd_saw8", n < 30, 1'b1);
        hold = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #3;
        check_bit("rd_cyc_req", imem_req, 1'b0);
        check_bit("rd_cyc_valid", instr_valid, 1'b0);
        hold = 1'b0;
        delivered.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check_bit("rd_after_req", imem_req, 1'b0);
        for (n = 0; n < 10; n++) begin
            @(negedge clk); #3;
            if (imem_req) break;
        end
        check_bit("rd_req_found", n < 10, 1'b1);
        check("rd_addr", imem_addr, 32'h100);
        for (n = 0; n < 10; n++) begin
            @(negedge clk); #3;
            if (instr_valid) break;
        end
        check_bit("rd_valid_found", n < 10, 1'b1);
        check("rd_pc", instr_pc, 32'h100);
        check("rd_data", instr, mw(32'h100));

        // Grant stall
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        a0 = imem_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            check_bit("stall_req", imem_req, 1'b1);
            check("stall_addr", imem_addr, a0);
        end
        @(negedge clk);
        imem_gnt = 1'b1;
        delivered.delete();
        #3;
        check_bit("stall_grant_req", imem_req, 1'b1);
        @(negedge clk);
        imem_gnt = 1'b0;
        #3;
        check("stall_adv", imem_addr, a0 + 32'd4);
        repeat (4) @(negedge clk);
        #3;
        check("stall_count", 32'(delivered.size()), 32'd1);
        if (delivered.size() == 1) check("stall_pc", delivered[0], a0);

        // Misaligned redirect while the FIFO holds data
        @(negedge clk);
        imem_gnt = 1'b1; instr_ready = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk); #3;
            if (instr_valid) break;
        end
        check_bit("ma_fill", n < 20, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        #3;
        check_bit("ma_cyc_valid", instr_valid, 1'b0);
        check_bit("ma_cyc_req", imem_req, 1'b0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        check_bit("ma_flush", instr_valid, 1'b0);
        for (n = 0; n < 10; n++) begin
            if (imem_req) break;
            @(negedge clk); #3;
        end
        check_bit("ma_req_found", n < 10, 1'b1);
        check("ma_addr", imem_addr, 32'h200);
        @(negedge clk);
        instr_ready = 1'b1;
        for (n = 0; n < 10; n++) begin
            #3;
            if (instr_valid) break;
            @(negedge clk);
        end
        check_bit("ma_valid_found", n < 10, 1'b1);
        check("ma_pc", instr_pc, 32'h200);
        check("ma_data", instr, mw(32'h200));

        // Address wrap
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        delivered.delete();
        #3;
        for (n = 0; n < 10; n++) begin
            if (imem_req) break;
            @(negedge clk); #3;
        end
        check_bit("wr_req_found", n < 10, 1'b1);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        check("wr_addr_next", imem_addr, 32'h0);
        repeat (6) @(negedge clk);
        #3;
        check_bit("wr_count", delivered.size() >= 2, 1'b1);
        if (delivered.size() >= 2) begin
            check("wr_seq0", delivered[0], 32'hFFFF_FFFC);
            check("wr_seq1", delivered[1], 32'h0);
        end

        // Asynchronous reset with a full FIFO
        @(negedge clk);
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        check_bit("ar_full_req", imem_req, 1'b0);
        check_bit("ar_full_valid", instr_valid, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("ar_valid", instr_valid, 1'b0);
        check_bit("ar_req", imem_req, 1'b0);
        check("ar_instr", instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; imem_gnt = 1'b0;
        #3;
        stray = 1'b1;
        check("ar_addr_rel", imem_addr, RESET_PC);
        @(negedge clk); #3;
        stray = 1'b0;
        check_bit("ar_stray_valid", instr_valid, 1'b0);
        check("ar_stray_addr", imem_addr, RESET_PC);
        @(negedge clk);
        imem_gnt = 1'b1; instr_ready = 1'b1;
        #3;
        check_bit("ar_req0", imem_req, 1'b1);
        check("ar_addr0", imem_addr, RESET_PC);
        for (n = 0; n < 10; n++) begin
            @(negedge clk); #3;
            if (instr_valid) break;
        end
        check_bit("ar_valid_found", n < 10, 1'b1);
        check("ar_pc", instr_pc, RESET_PC);
        check("ar_data", instr, mw(RESET_PC));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
